timer: RTL and testbench

TIMER -- requirements
Module: timer

---
 rtl/timer.sv | 37 +++
 tb/tb_timer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/timer.sv
// timer: prescaled elapsed-seconds counter (saturating at 9:59) with a signed, clamped BCD display offset
module timer #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       count,
  input  logic [8:0] adder,
  output logic [3:0] seconds0,
  output logic [3:0] seconds1,
  output logic [3:0] minutes0
);
  localparam int PW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
  logic [PW-1:0] presc;
  logic [9:0] elapsed;
  logic wrap;
  logic signed [11:0] sum;
  logic [9:0] disp;
  logic [9:0] rem;
  assign wrap = presc == PW'(TICKS_PER_SEC - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      presc <= '0;
      elapsed <= '0;
    end else if (count) begin
      presc <= wrap ? '0 : presc + 1'b1;
      if (wrap && elapsed != 10'd599) elapsed <= elapsed + 1'b1;
    end
  always_comb begin
    sum = $signed({2'b00, elapsed}) + $signed({{3{adder[8]}}, adder});
    disp = sum[11] ? 10'd0 : (sum > 12'sd599 ? 10'd599 : sum[9:0]);
    rem = disp % 10'd60;
    minutes0 = 4'(disp / 10'd60);
    seconds1 = 4'(rem / 10'd10);
    seconds0 = 4'(rem % 10'd10);
  end
endmodule

// File: tb/tb_timer.sv
// tb_timer: scenario tasks for two timer instances (4 and 1 ticks/s) checked against an edge-counting reference model
module tb_timer;
  logic clk = 0;
  logic reset4 = 1, count4 = 0, reset1 = 1, count1 = 0;
  logic [8:0] adder4 = 0, adder1 = 0;
  logic [3:0] s0_4, s1_4, m0_4, s0_1, s1_1, m0_1;
  wire [11:0] o4 = {m0_4, s1_4, s0_4};
  wire [11:0] o1 = {m0_1, s1_1, s0_1};
  int n4 = 0, n1 = 0;
  int pass = 0, total = 0;

  timer #(.TICKS_PER_SEC(4)) dut4 (.clk(clk), .reset(reset4), .count(count4), .adder(adder4),
    .seconds0(s0_4), .seconds1(s1_4), .minutes0(m0_4));
  timer #(.TICKS_PER_SEC(1)) dut1 (.clk(clk), .reset(reset1), .count(count1), .adder(adder1),
    .seconds0(s0_1), .seconds1(s1_1), .minutes0(m0_1));

  always #5 clk = ~clk;

  // Elapsed seconds are simply enabled edges since reset divided by the rate, capped at 599.
  function automatic logic [11:0] model(int edges, int tps, logic [8:0] a);
    int e, d;
    e = edges / tps;
    if (e > 599) e = 599;
    d = e + int'($signed(a));
    if (d < 0) d = 0;
    if (d > 599) d = 599;
    return {4'(d / 60), 4'((d % 60) / 10), 4'(d % 10)};
  endfunction

  task automatic step(int k);
    for (int i = 0; i < k; i++) begin
      if (count4 && !reset4) n4++;
      if (count1 && !reset1) n1++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset4();
    reset4 = 1; n4 = 0; count4 = 0;
    step(2);
    reset4 = 0;
  endtask

  task automatic test_reset();
    adder4 = 0;
    step(1);
    total++;
    if (o4 !== 12'h000) $display("FAIL reset_zero got %h want 000", o4); else pass++;
    adder4 = 30; #1;
    total++;
    if (o4 !== 12'h030) $display("FAIL reset_adder30 got %h want 030", o4); else pass++;
  endtask

  task automatic test_comb_adder();
    reset4 = 0; count4 = 0; adder4 = 1; #1;
    total++;
    if (o4 !== 12'h001) $display("FAIL comb_adder1 got %h want 001", o4); else pass++;
    adder4 = 30; #1;
    total++;
    if (o4 !== 12'h030) $display("FAIL comb_adder30 got %h want 030", o4); else pass++;
  endtask

  task automatic test_count_pause();
    do_reset4();
    adder4 = 0; count4 = 1;
    step(260);
    total++;
    if (o4 !== 12'h105 || o4 !== model(n4, 4, adder4)) $display("FAIL count_260 got %h want 105", o4); else pass++;
    count4 = 0;
    step(20);
    total++;
    if (o4 !== 12'h105) $display("FAIL pause_20 got %h want 105", o4); else pass++;
  endtask

  task automatic test_offset();
    do_reset4();
    adder4 = 0; count4 = 1;
    step(12);
    count4 = 0;
    adder4 = -9'sd5; #1;
    total++;
    if (o4 !== 12'h000) $display("FAIL offset_neg got %h want 000", o4); else pass++;
    adder4 = 9'd70; #1;
    total++;
    if (o4 !== 12'h113) $display("FAIL offset_pos got %h want 113", o4); else pass++;
    adder4 = 0; #1;
    total++;
    if (o4 !== 12'h003) $display("FAIL offset_removed got %h want 003", o4); else pass++;
  endtask

  task automatic test_saturate();
    reset1 = 0; count1 = 1; adder1 = 0;
    step(700);
    total++;
    if (o1 !== 12'h959) $display("FAIL sat_700 got %h want 959", o1); else pass++;
    adder1 = 9'd255; #1;
    total++;
    if (o1 !== 12'h959) $display("FAIL sat_plus255 got %h want 959", o1); else pass++;
    adder1 = 9'h100; #1;
    total++;
    if (o1 !== 12'h543) $display("FAIL sat_minus256 got %h want 543", o1); else pass++;
    count1 = 0;
  endtask

  task automatic test_reset_mid();
    do_reset4();
    adder4 = 0; count4 = 1;
    step(6);
    reset4 = 1; n4 = 0; #1;
    total++;
    if (o4 !== 12'h000) $display("FAIL midreset_async got %h want 000", o4); else pass++;
    step(2);
    reset4 = 0;
    step(3);
    total++;
    if (o4 !== 12'h000) $display("FAIL midreset_3edges got %h want 000", o4); else pass++;
    step(1);
    total++;
    if (o4 !== 12'h001) $display("FAIL midreset_4th got %h want 001", o4); else pass++;
  endtask

  task automatic test_random();
    do_reset4();
    for (int i = 0; i < 400; i++) begin
      count4 = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 7) == 0) adder4 = 9'($urandom_range(0, 511));
      step(1);
      total++;
      if (o4 !== model(n4, 4, adder4))
        $display("FAIL random_cycle%0d got %h want %h", i, o4, model(n4, 4, adder4));
      else pass++;
    end
  endtask

  initial begin
    test_reset();
    test_comb_adder();
    test_count_pause();
    test_offset();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
